// File: rtl/cordic_batch_driver.sv
// cordic_batch_driver: streaming front end for a CORDIC_Arch2-style core.
// Commands are queued in a FIFO and issued one at a time through the
// begin/ready/acknowledge handshake. Each result, or a timeout marker when
// the core hangs, lands in a first-word fall-through result FIFO.
module cordic_batch_driver #(
  parameter int W       = 32,
  parameter int DW      = 4,
  parameter int TW      = 8,
  parameter int TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_angle,
  input  logic         in_op,
  input  logic [1:0]   in_region,
  output logic         core_beg,
  output logic         core_ack,
  output logic         core_operation,
  output logic [W-1:0] core_data_in,
  output logic [1:0]   core_shift_region,
  input  logic         core_ready,
  input  logic [W-1:0] core_data_out,
  input  logic         core_ovf,
  input  logic         core_unf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         out_unf,
  output logic         out_timeout,
  output logic         busy,
  output logic [7:0]   err_count
);

  localparam int            DEPTH    = 2 ** DW;
  localparam int            EW       = W + 3;
  localparam logic [DW:0]   FULL_CNT = (DW + 1)'(DEPTH);
  localparam logic [TW-1:0] TO_CNT   = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  state_t        state;
  logic [TW-1:0] wait_cnt;

  logic [EW-1:0] cmd_mem [DEPTH];
  logic [DW-1:0] cmd_wr;
  logic [DW-1:0] cmd_rd;
  logic [DW:0]   cmd_cnt;
  logic [EW-1:0] res_mem [DEPTH];
  logic [DW-1:0] res_wr;
  logic [DW-1:0] res_rd;
  logic [DW:0]   res_cnt;

  logic          cmd_push;
  logic          cmd_pop;
  logic          res_push;
  logic          res_pop;
  logic          res_full;
  logic          res_err;
  logic [EW-1:0] cmd_head;
  logic [EW-1:0] res_head;
  logic [EW-1:0] res_wdata;

  // A command is only taken when a result slot is already free, so the
  // result push at the end of WAIT can never meet a full FIFO.
  assign in_ready  = (cmd_cnt != FULL_CNT);
  assign cmd_push  = in_valid && in_ready;
  assign res_full  = (res_cnt == FULL_CNT);
  assign cmd_pop   = (state == IDLE) && (cmd_cnt != '0) && !res_full;
  assign cmd_head  = cmd_mem[cmd_rd];

  // Real data always beats the timeout when both land on the same cycle.
  assign res_push  = (state == WAIT) && (core_ready || (wait_cnt == TO_CNT));
  assign res_wdata = core_ready ? {core_data_out, core_ovf, core_unf, 1'b0}
                                : {{W{1'b0}}, 3'b001};
  assign res_err   = |res_wdata[2:0];

  // The head is masked while empty so the outputs read zero after reset.
  assign out_valid   = (res_cnt != '0);
  assign res_pop     = out_valid && out_ready;
  assign res_head    = out_valid ? res_mem[res_rd] : '0;
  assign out_data    = res_head[EW-1:3];
  assign out_ovf     = res_head[2];
  assign out_unf     = res_head[1];
  assign out_timeout = res_head[0];
  assign busy        = (state != IDLE);

  // FIFO storage, written without reset since emptiness is tracked by counts.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr] <= {in_angle, in_op, in_region};
    if (res_push) res_mem[res_wr] <= res_wdata;
  end

  // FIFO pointers, fill counts and the saturating error counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_wr    <= '0;
      cmd_rd    <= '0;
      cmd_cnt   <= '0;
      res_wr    <= '0;
      res_rd    <= '0;
      res_cnt   <= '0;
      err_count <= '0;
    end else begin
      if (cmd_push) cmd_wr <= cmd_wr + DW'(1);
      if (cmd_pop)  cmd_rd <= cmd_rd + DW'(1);
      cmd_cnt <= cmd_cnt + {{DW{1'b0}}, cmd_push} - {{DW{1'b0}}, cmd_pop};
      if (res_push) res_wr <= res_wr + DW'(1);
      if (res_pop)  res_rd <= res_rd + DW'(1);
      res_cnt <= res_cnt + {{DW{1'b0}}, res_push} - {{DW{1'b0}}, res_pop};
      if (res_push && res_err && (err_count != 8'hff)) err_count <= err_count + 8'd1;
    end
  end

  // Handshake sequencer with registered strobes and held operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      core_beg          <= 1'b0;
      core_ack          <= 1'b0;
      core_operation    <= 1'b0;
      core_data_in      <= '0;
      core_shift_region <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_pop) begin
            core_data_in      <= cmd_head[EW-1:3];
            core_operation    <= cmd_head[2];
            core_shift_region <= cmd_head[1:0];
            core_beg          <= 1'b1;
            state             <= START;
          end
        end
        START: begin
          core_beg <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (res_push) begin
            core_ack <= 1'b1;
            state    <= ACK;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ACK: begin
          if (!core_ready) begin
            core_ack <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cordic_batch_driver.md
# cordic_batch_driver

Parametrised hardware sequencer that feeds a CORDIC_Arch2-style core from a command FIFO and collects results into a result FIFO. It replaces bench-style one-angle-at-a-time driving with a synthesizable streaming front end. It runs the full begin/ready/acknowledge handshake, applies per-command operation and region, detects hung cores by timeout, and counts error results. It sits between the FPU interface stream and the CORDIC core.

## Interface
- W, 32, data width (32 single, 64 double)
- DW, 4, log2 of each FIFO depth (depth = 2**DW)
- TW, 8, timeout counter width
- TIMEOUT, 200, max WAIT cycles before abort (1 ≤ TIMEOUT ≤ 2**TW-1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- in_valid  in  1  command offered
- in_ready  out  1  command FIFO not full
- in_angle  in  W  angle, radians, IEEE-754
- in_op  in  1  1 = sine, 0 = cosine
- in_region  in  2  shift region flag for the command
- core_beg  out  1  begin pulse to core
- core_ack  out  1  result acknowledge to core
- core_operation  out  1  operation held to core
- core_data_in  out  W  angle held to core
- core_shift_region  out  2  region held to core
- core_ready  in  1  core result valid
- core_data_out  in  W  core result
- core_ovf, core_unf  in  1 each  core flags
- out_valid  out  1  result FIFO not empty
- out_ready  in  1  consumer pops head
- out_data  out  W  head result
- out_ovf, out_unf, out_timeout  out  1 each  head flags
- busy  out  1  FSM not in IDLE
- err_count  out  8  saturating count of results pushed with any flag set

## Operation
- Command FIFO: entries {angle, op, region}. Push on in_valid & in_ready. Result FIFO: entries {data, ovf, unf, timeout}, first-word fall-through; pop on out_valid & out_ready.
- Both FIFOs: simultaneous push and pop legal at any fill. Full: push blocked (in_ready=0). Empty: pop ignored. Pointers wrap modulo 2**DW.
- FSM states: IDLE, START, WAIT, ACK.
  - IDLE: when the command FIFO is non-empty and the result FIFO is not full, pop the command, latch it onto core_operation/core_data_in/core_shift_region, and go to START.
  - START: core_beg=1 for exactly one cycle, then go to WAIT with the timeout counter at 0.
  - WAIT: when core_ready=1, push {core_data_out, core_ovf, core_unf, 0} and go to ACK. Else, when the counter reaches TIMEOUT, push {0, 0, 0, 1} and go to ACK. Else increment the counter. If core_ready and the timeout coincide, core_ready wins.
  - ACK: core_ack=1; remain while core_ready=1; go to IDLE on the first cycle core_ready=0. Minimum one ACK cycle.
- Only one command is in flight. The result slot is guaranteed by the IDLE check, so a push never hits a full FIFO.
- err_count increments on each push with ovf|unf|timeout set and saturates at 255.
- Core-side operand registers hold their value from the IDLE→START edge until the next command is latched.

## Timing
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE, both FIFOs empty, counters 0.
  - core_beg, core_ack, core_operation, core_data_in, core_shift_region = 0.
  - out_valid, out_data, and out flags = 0; busy = 0; err_count = 0; in_ready = 1.
  - Reset mid-operation abandons the in-flight command and all FIFO contents, with no result pushed. core_ack drops immediately.
- Latency, command push edge e0:
  - IDLE latches the command at e1.
  - core_beg is high during e1–e2.
  - WAIT starts at e2.
  - If core_ready is sampled high at edge eN, out_valid is high after eN (when the FIFO was empty) and core_ack is high after eN.
- Timeout: with core_ready stuck at 0, the result is pushed TIMEOUT+1 cycles after WAIT entry.
- Throughput: IDLE→START→WAIT(≥1)→ACK(≥1) gives at least 4 cycles per command.
- core_beg and core_ack are registered, glitch-free, and never high simultaneously.

## Test plan
- Single cosine: push angle 32'h3f25514d, op=0, region=00; model core answers ready 10 cycles after beg. Required: one core_beg pulse, operands stable, out_data = model value, flags 0, err_count 0.
- Burst of 16 commands (DW=4) with out_ready=0. Required: in_ready drops only at 16 entries in the command FIFO. Results stop being dispatched when the result FIFO is full (16) and resume one per pop, with order preserved.
- Hung core: core_ready held 0, TIMEOUT=20. Required: result {0, timeout=1} appears 21 cycles after WAIT entry, core_ack pulses for one cycle, err_count=1.
- core_ready asserted on the exact cycle the counter hits TIMEOUT. Required: real data is pushed, out_timeout=0.
- Core holds core_ready for 5 cycles after ack. Required: core_ack stays high 5 cycles, and the next core_beg occurs no earlier than one cycle after core_ready falls.
- rst pulsed low while in WAIT with 3 queued commands. Required: all outputs return to reset values immediately. No result is emitted for the dropped commands, and the next pushed command runs normally.
